// File: rtl/refresh_pkg.sv
// refresh_pkg: shared types and helpers for the DRAM refresh request generator.
package refresh_pkg;

    // Request state machine encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        URG  = 2'd2,
        GAP  = 2'd3
    } ref_state_t;

    // Width of the owed-refresh counter / status port
    localparam int DEBT_W = 2;

    // Counter width able to hold 0 .. n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            cnt_width = 1;
        end else begin
            cnt_width = $clog2(n);
        end
    endfunction

endpackage

// File: rtl/refresh_tick.sv
// refresh_tick: free-running divider that pulses Tick for one cycle every
// REF_PERIOD cycles. Tick is registered and coincides with the counter's
// terminal value, so the first pulse is sampled REF_PERIOD edges after reset.
module refresh_tick
    import refresh_pkg::*;
#(
    parameter int REF_PERIOD = 390
) (
    input  logic CLK,
    input  logic Reset,
    output logic Tick
);

    localparam int              CW       = cnt_width(REF_PERIOD);
    localparam logic [CW-1:0]   CNT_LAST = CW'(REF_PERIOD - 1);
    localparam logic [CW-1:0]   CNT_PRE  = CW'(REF_PERIOD - 2);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Divider counter and registered tick, raised together with the wrap value
    always_ff @(posedge CLK) begin
        if (Reset) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            if (cnt_r == CNT_LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
            tick_r <= (cnt_r == CNT_PRE);
        end
    end

    assign Tick = tick_r;

endmodule

// File: rtl/refresh_gen.sv
// refresh_gen: DRAM refresh request generator. Counts owed refreshes, raises
// RefReq, escalates to RefUrg when a request ages or debt piles up, and
// inserts a one-cycle gap after every serviced refresh.
// Optional feature macro: REFRESH_DEBT_EN (multi-entry saturating debt counter
// and debt-based escalation). Without it, debt is a single pending bit.
module refresh_gen
    import refresh_pkg::*;
#(
    parameter int REF_PERIOD = 390,
    parameter int URG_DELAY  = 128,
    parameter int MAX_DEBT   = 3
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              RefAck,
    output logic              RefReq,
    output logic              RefUrg,
    output logic [DEBT_W-1:0] RefDebt,
    output logic              RefOverrun
);

    localparam int            AW       = cnt_width(URG_DELAY);
    localparam logic [AW-1:0] AGE_LAST = AW'(URG_DELAY - 1);

    logic              tick_s;
    ref_state_t        state_r;
    ref_state_t        state_next_s;
    logic [AW-1:0]     age_r;
    logic [DEBT_W-1:0] debt_r;
    logic [DEBT_W-1:0] debt_next_s;
    logic              overrun_set_s;
    logic              debt_hi_s;
    logic              debt_hi_r;
    logic              req_r;
    logic              urg_r;
    logic              overrun_r;

    refresh_tick #(
        .REF_PERIOD (REF_PERIOD)
    ) u_tick (
        .CLK   (CLK),
        .Reset (Reset),
        .Tick  (tick_s)
    );

`ifdef REFRESH_DEBT_EN
    localparam logic [DEBT_W-1:0] DEBT_MAX = DEBT_W'(MAX_DEBT);

    // Saturating debt update; a tick and an ack in the same cycle cancel out
    always_comb begin
        debt_next_s   = debt_r;
        overrun_set_s = 1'b0;
        if (tick_s && !RefAck) begin
            if (debt_r == DEBT_MAX) begin
                overrun_set_s = 1'b1;
            end else begin
                debt_next_s = debt_r + DEBT_W'(1);
            end
        end else if (RefAck && !tick_s) begin
            if (debt_r != DEBT_W'(0)) begin
                debt_next_s = debt_r - DEBT_W'(1);
            end else begin
                debt_next_s = debt_r;
            end
        end else begin
            debt_next_s = debt_r;
        end
    end

    assign debt_hi_s = (debt_r >= DEBT_W'(2));
`else
    // Single pending bit; a tick that finds it still set is a lost refresh
    always_comb begin
        debt_next_s   = debt_r;
        overrun_set_s = 1'b0;
        if (tick_s && !RefAck) begin
            if (debt_r[0]) begin
                overrun_set_s = 1'b1;
            end else begin
                debt_next_s = DEBT_W'(1);
            end
        end else if (RefAck && !tick_s) begin
            debt_next_s = DEBT_W'(0);
        end else begin
            debt_next_s = debt_r;
        end
    end

    assign debt_hi_s = 1'b0;
`endif

    // Next-state logic; debt escalation uses the registered debt_hi_r flag,
    // so it takes effect two cycles after the tick that raised the debt
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (debt_r != DEBT_W'(0)) begin
                    state_next_s = REQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                if (RefAck) begin
                    state_next_s = GAP;
                end else if ((age_r == AGE_LAST) || debt_hi_r) begin
                    state_next_s = URG;
                end else begin
                    state_next_s = REQ;
                end
            end
            URG: begin
                if (RefAck) begin
                    state_next_s = GAP;
                end else begin
                    state_next_s = URG;
                end
            end
            GAP: begin
                if (debt_r != DEBT_W'(0)) begin
                    state_next_s = REQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Debt, age counter, overrun flag and outputs decoded from the next state
    always_ff @(posedge CLK) begin
        if (Reset) begin
            debt_r    <= '0;
            debt_hi_r <= 1'b0;
            age_r     <= '0;
            req_r     <= 1'b0;
            urg_r     <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            debt_r    <= debt_next_s;
            debt_hi_r <= debt_hi_s;
            if ((state_r == REQ) && (state_next_s == REQ)) begin
                age_r <= age_r + AW'(1);
            end else begin
                age_r <= '0;
            end
            req_r     <= (state_next_s == REQ) || (state_next_s == URG);
            urg_r     <= (state_next_s == URG);
            overrun_r <= overrun_r | overrun_set_s;
        end
    end

    assign RefReq     = req_r;
    assign RefUrg     = urg_r;
    assign RefDebt    = debt_r;
    assign RefOverrun = overrun_r;

endmodule

// File: tb/tb_refresh_gen.sv
// tb_refresh_gen: directed self-checking bench for refresh_gen.
// Cycle 0 is the last rising edge with Reset high; cycle n is the n-th edge
// after it. Outputs are sampled 1 time unit after each rising edge.
module tb_refresh_gen;

    localparam int P  = 16;
    localparam int UD = 4;
    localparam int MD = 3;
`ifdef REFRESH_DEBT_EN
    localparam bit DEBT_EN = 1'b1;
`else
    localparam bit DEBT_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       Reset;
    logic       RefAck;
    logic       RefReq;
    logic       RefUrg;
    logic [1:0] RefDebt;
    logic       RefOverrun;

    int   cyc;
    int   n_checks;
    int   n_fail;
    logic urg_seen;

    refresh_gen #(
        .REF_PERIOD (P),
        .URG_DELAY  (UD),
        .MAX_DEBT   (MD)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .RefAck     (RefAck),
        .RefReq     (RefReq),
        .RefUrg     (RefUrg),
        .RefDebt    (RefDebt),
        .RefOverrun (RefOverrun)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
        urg_seen = urg_seen | RefUrg;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) begin
            step();
        end
    endtask

    task automatic do_reset();
        Reset  = 1'b1;
        RefAck = 1'b0;
        step();
        step();
        Reset    = 1'b0;
        cyc      = 0;
        urg_seen = 1'b0;
    endtask

    // Pulse RefAck so that it is sampled at edge n
    task automatic ack_at(input int n);
        run_to(n - 1);
        RefAck = 1'b1;
        step();
        RefAck = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        urg_seen = 1'b0;

        // A: no acks -- first request, age escalation, debt growth, overrun
        do_reset();
        check("rst_req",  32'(RefReq),     32'd0);
        check("rst_urg",  32'(RefUrg),     32'd0);
        check("rst_debt", 32'(RefDebt),    32'd0);
        check("rst_ovr",  32'(RefOverrun), 32'd0);
        run_to(16);
        check("a16_req",  32'(RefReq),  32'd0);
        check("a16_debt", 32'(RefDebt), 32'd1);
        run_to(17);
        check("a17_req", 32'(RefReq), 32'd1);
        check("a17_urg", 32'(RefUrg), 32'd0);
        run_to(20);
        check("a20_urg", 32'(RefUrg), 32'd0);
        run_to(21);
        check("a21_urg", 32'(RefUrg), 32'd1);
        check("a21_req", 32'(RefReq), 32'd1);
        run_to(31);
        check("a31_ovr", 32'(RefOverrun), 32'd0);
        run_to(32);
        check("a32_debt", 32'(RefDebt),    DEBT_EN ? 32'd2 : 32'd1);
        check("a32_ovr",  32'(RefOverrun), DEBT_EN ? 32'd0 : 32'd1);
        run_to(34);
        check("a34_urg", 32'(RefUrg), 32'd1);
        run_to(63);
        check("a63_debt", 32'(RefDebt),    DEBT_EN ? 32'd3 : 32'd1);
        check("a63_ovr",  32'(RefOverrun), DEBT_EN ? 32'd0 : 32'd1);
        run_to(64);
        check("a64_debt", 32'(RefDebt),    DEBT_EN ? 32'd3 : 32'd1);
        check("a64_ovr",  32'(RefOverrun), 32'd1);

        // B: ack two cycles after every request rise
        do_reset();
        for (int k = 0; k < 3; k++) begin
            run_to(16 * k + 18);
            check("b_req_hi",  32'(RefReq), 32'd1);
            check("b_urg_lo",  32'(RefUrg), 32'd0);
            ack_at(16 * k + 19);
            check("b_gap_req", 32'(RefReq),  32'd0);
            check("b_debt0",   32'(RefDebt), 32'd0);
            step();
            check("b_idle_req", 32'(RefReq), 32'd0);
        end
        check("b_urg_never", 32'(urg_seen), 32'd0);

        // C: withhold acks for two ticks, then ack once
        do_reset();
        run_to(39);
        check("c39_req",  32'(RefReq),  32'd1);
        check("c39_urg",  32'(RefUrg),  32'd1);
        check("c39_debt", 32'(RefDebt), DEBT_EN ? 32'd2 : 32'd1);
        ack_at(40);
        check("c40_req",  32'(RefReq),  32'd0);
        check("c40_urg",  32'(RefUrg),  32'd0);
        check("c40_debt", 32'(RefDebt), DEBT_EN ? 32'd1 : 32'd0);
        run_to(41);
        check("c41_req", 32'(RefReq), DEBT_EN ? 32'd1 : 32'd0);
        check("c41_urg", 32'(RefUrg), 32'd0);
        run_to(45);
        check("c45_urg", 32'(RefUrg), DEBT_EN ? 32'd1 : 32'd0);

        // D: ack in the same cycle as a tick
        do_reset();
        run_to(31);
        check("d31_debt", 32'(RefDebt), 32'd1);
        ack_at(32);
        check("d32_debt", 32'(RefDebt),    32'd1);
        check("d32_req",  32'(RefReq),     32'd0);
        check("d32_ovr",  32'(RefOverrun), 32'd0);
        run_to(33);
        check("d33_req", 32'(RefReq), 32'd1);
        check("d33_urg", 32'(RefUrg), 32'd0);

        // E: one-cycle reset while urgent, tick phase restarts
        do_reset();
        run_to(25);
        check("e25_urg", 32'(RefUrg), 32'd1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("e_rst_req",  32'(RefReq),  32'd0);
        check("e_rst_urg",  32'(RefUrg),  32'd0);
        check("e_rst_debt", 32'(RefDebt), 32'd0);
        run_to(42);
        check("e42_req",  32'(RefReq),  32'd0);
        check("e42_debt", 32'(RefDebt), 32'd1);
        run_to(43);
        check("e43_req", 32'(RefReq), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/refresh_gen.md
# refresh_gen

Refresh request generator driving the DRAM controller's `RefReqIn`/`RefUrgIn` inputs. It times the DRAM refresh interval, tracks owed refreshes, and raises a normal request that escalates to urgent if not serviced. It retires a request when the controller reports a refresh. Between consecutive requests it drops `RefReq` for at least one cycle so the controller's "refresh done" latch re-arms.

## Interface
- `REF_PERIOD`, 390: clock cycles between refresh ticks (15.6 µs at 25 MHz); must be ≥ 4.
- `URG_DELAY`, 128: cycles a request may stay non-urgent before escalating; must be ≥ 1 and < `REF_PERIOD`.
- `MAX_DEBT`, 3: saturation value of the owed-refresh counter (with `REFRESH_DEBT_EN`).
- `CLK` in 1: system clock; all logic on the rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `RefAck` in 1: one-cycle pulse from the DRAM controller on the first cycle of refresh RAS (refresh state 4 entered).
- `RefReq` out 1: refresh requested; goes to controller `RefReqIn`.
- `RefUrg` out 1: refresh urgent; goes to controller `RefUrgIn`. Never high while `RefReq` is low.
- `RefDebt` out 2: current owed-refresh count (status).
- `RefOverrun` out 1: sticky flag, set when a tick is lost. Cleared only by `Reset`.

## Operation
- Tick divider counts 0 → `REF_PERIOD`-1 and wraps. It asserts `Tick` for one cycle at the wrap. It free-runs and never stalls.
- Debt counter:
  - `Tick` alone: +1.
  - `RefAck` alone (debt > 0): −1.
  - Both in the same cycle: unchanged.
  - `RefAck` with debt 0: ignored, debt stays 0.
  - `Tick` at debt = `MAX_DEBT`: debt holds and `RefOverrun` is set.
- State machine (registered outputs):
  - IDLE: `RefReq`=0, `RefUrg`=0. Go to REQ when debt > 0.
  - REQ: `RefReq`=1, `RefUrg`=0. An age counter runs from 0.
    - `RefAck` → GAP.
    - Otherwise, age = `URG_DELAY`-1 or debt ≥ 2 → URG.
  - URG: `RefReq`=1, `RefUrg`=1. `RefAck` → GAP.
  - GAP: both outputs 0 for exactly one cycle. Then go to REQ if post-ack debt > 0, else IDLE. Age counter clears.
- `RefAck` in IDLE or GAP does not change state. It still decrements debt if debt > 0.
- `Reset` at any point, including mid-request, forces:
  - state IDLE, all counters 0, every output 0;
  - the tick phase restarts.

## Timing
- Reset values: `RefReq`=0, `RefUrg`=0, `RefDebt`=0, `RefOverrun`=0.
- First `Tick` comes `REF_PERIOD` cycles after the cycle `Reset` is sampled low. `RefReq` rises the following cycle, giving a tick-to-request latency of 1 cycle.
- `RefAck` at cycle n: `RefReq`/`RefUrg` are low at n+1 (GAP). With debt still owed, `RefReq` is high again at n+2.
- Escalation with debt 1: `RefUrg` rises `URG_DELAY` cycles after `RefReq` rose.
- Escalation on debt reaching 2 while in REQ: `RefUrg` rises 2 cycles after that `Tick`.

## Configuration
- `REFRESH_DEBT_EN` defined:
  - debt counter is 2 bits, saturating at `MAX_DEBT`;
  - `RefOverrun` sets only on a tick at saturation.
- `REFRESH_DEBT_EN` undefined:
  - debt is a single pending bit and `MAX_DEBT` is ignored;
  - the "debt ≥ 2" escalation path is absent, so escalation happens on age only;
  - a `Tick` while pending with no same-cycle `RefAck` sets `RefOverrun`;
  - `RefDebt` reports {0, pending}.

## Structure
- Package `refresh_pkg` holds:
  - the state enum `ref_state_t` {IDLE, REQ, URG, GAP};
  - a `clog2`-based width constant helper for the divider and age counters.
- One sub-module, `refresh_tick`: a parameterised free-running divider emitting `Tick`, with synchronous `Reset`. The FSM, debt counter, age counter and overrun flag live in `refresh_gen`.

## Test plan
Bench parameters: `REF_PERIOD`=16, `URG_DELAY`=4, `MAX_DEBT`=3.
- Release reset, no acks: `RefReq` rises at cycle 17. `RefUrg` rises at cycle 21, then debt ≥ 2 after the tick at 32 keeps it urgent. `RefOverrun` is set at the 4th tick (cycle 64).
- `RefAck` pulsed 2 cycles after each `RefReq` rise: `RefUrg` never asserts, `RefDebt` returns to 0, and `RefReq` shows a 1-cycle-low GAP after each ack.
- Withhold acks for 2 ticks, then ack once: debt goes 2→1, `RefReq` is low for exactly one cycle, then high again the next cycle.
- `RefAck` coincident with `Tick`: debt is unchanged and the FSM still enters GAP.
- Assert `Reset` for one cycle while in URG: next cycle all outputs are 0, and the next request comes 16 cycles after reset release.
- With `REFRESH_DEBT_EN` undefined: a tick while pending sets `RefOverrun`, and `RefUrg` rises only 4 cycles after `RefReq`.
